// File: rtl/qupls_decode_erc_pipe.sv
// Multi-lane ERC decode stage: classifies each lane against a programmable
// opcode mask, registers the bundle behind a valid/ready skid buffer and
// keeps a saturating count of ERC instructions delivered downstream.
module qupls_decode_erc_pipe #(
  parameter int unsigned LANES = 4,
  parameter int unsigned INSTW = 41,
  parameter int unsigned OPW   = 7,
  parameter int unsigned CNTW  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*INSTW-1:0]     in_instr,
  input  logic [LANES-1:0]           in_lmask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*INSTW-1:0]     out_instr,
  output logic [LANES-1:0]           out_lmask,
  output logic [LANES-1:0]           out_erc,
  output logic                       out_any_erc,
  output logic [$clog2(LANES)-1:0]   out_first_erc,
  input  logic                       mask_we,
  input  logic [OPW-1:0]             mask_adr,
  input  logic                       mask_din,
  input  logic                       cnt_clr,
  output logic [CNTW-1:0]            erc_count
);

  localparam int unsigned MDEPTH = 2**OPW;
  localparam int unsigned BW     = LANES*INSTW;
  localparam int unsigned FW     = $clog2(LANES);
  localparam int unsigned PW     = $clog2(LANES+1);

  logic [MDEPTH-1:0] mask_q;
  logic [LANES-1:0]  in_erc_c;

  logic              skid_valid_q, skid_valid_d;
  logic [BW-1:0]     skid_instr_q, skid_instr_d;
  logic [LANES-1:0]  skid_lmask_q, skid_lmask_d;
  logic [LANES-1:0]  skid_erc_q,   skid_erc_d;

  logic              out_valid_q, out_valid_d;
  logic [BW-1:0]     out_instr_q, out_instr_d;
  logic [LANES-1:0]  out_lmask_q, out_lmask_d;
  logic [LANES-1:0]  out_erc_q,   out_erc_d;
  logic              out_any_q,   out_any_d;
  logic [FW-1:0]     out_first_q, out_first_d;

  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]     pop_c;
  logic [CNTW:0]     sum_c;

  logic              in_fire_c, out_fire_c;

  // Lowest-index set lane; 0 when the vector is empty.
  function automatic logic [FW-1:0] first_set(input logic [LANES-1:0] v);
    logic [FW-1:0] r;
    r = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (v[i]) r = FW'(i);
    end
    return r;
  endfunction

  assign in_ready   = ~skid_valid_q & ~rst;
  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = out_valid_q & out_ready;

  // Per-lane classification against the current (pre-write) mask.
  always_comb begin
    in_erc_c = '0;
    for (int i = 0; i < LANES; i++) begin
      in_erc_c[i] = mask_q[in_instr[i*INSTW +: OPW]] & in_lmask[i];
    end
  end

  // Opcode mask storage; a write lands at the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else if (mask_we) begin
      mask_q[mask_adr] <= mask_din;
    end
  end

  // Skid-buffer steering and saturating event counter next state.
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_lmask_d = skid_lmask_q;
    skid_erc_d   = skid_erc_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_lmask_d  = out_lmask_q;
    out_erc_d    = out_erc_q;
    out_any_d    = out_any_q;
    out_first_d  = out_first_q;
    cnt_d        = cnt_q;
    pop_c        = '0;
    sum_c        = '0;

    if (out_fire_c || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_lmask_d  = skid_lmask_q;
        out_erc_d    = skid_erc_q;
        out_any_d    = |skid_erc_q;
        out_first_d  = first_set(skid_erc_q);
        skid_valid_d = 1'b0;
      end else if (in_fire_c) begin
        out_valid_d  = 1'b1;
        out_instr_d  = in_instr;
        out_lmask_d  = in_lmask;
        out_erc_d    = in_erc_c;
        out_any_d    = |in_erc_c;
        out_first_d  = first_set(in_erc_c);
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (in_fire_c) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_lmask_d = in_lmask;
      skid_erc_d   = in_erc_c;
    end

    for (int i = 0; i < LANES; i++) begin
      pop_c = pop_c + PW'(out_erc_q[i]);
    end
    sum_c = (CNTW+1)'(cnt_q) + (CNTW+1)'(pop_c);

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_fire_c) begin
      cnt_d = sum_c[CNTW] ? {CNTW{1'b1}} : sum_c[CNTW-1:0];
    end
  end

  // Pipeline, skid and counter registers; reset discards both held bundles.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_lmask_q <= '0;
      skid_erc_q   <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_lmask_q  <= '0;
      out_erc_q    <= '0;
      out_any_q    <= 1'b0;
      out_first_q  <= '0;
      cnt_q        <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_lmask_q <= skid_lmask_d;
      skid_erc_q   <= skid_erc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_lmask_q  <= out_lmask_d;
      out_erc_q    <= out_erc_d;
      out_any_q    <= out_any_d;
      out_first_q  <= out_first_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_instr     = out_instr_q;
  assign out_lmask     = out_lmask_q;
  assign out_erc       = out_erc_q;
  assign out_any_erc   = out_any_q;
  assign out_first_erc = out_first_q;
  assign erc_count     = cnt_q;

endmodule

// File: tb/tb_qupls_decode_erc_pipe.sv
// Directed bench for qupls_decode_erc_pipe (4 lanes, 4-bit counter).
module tb_qupls_decode_erc_pipe;

  localparam int unsigned LANES = 4;
  localparam int unsigned INSTW = 41;
  localparam int unsigned OPW   = 7;
  localparam int unsigned CNTW  = 4;
  localparam int unsigned BW    = LANES*INSTW;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [BW-1:0]    in_instr;
  logic [LANES-1:0] in_lmask;
  logic             out_valid;
  logic             out_ready;
  logic [BW-1:0]    out_instr;
  logic [LANES-1:0] out_lmask;
  logic [LANES-1:0] out_erc;
  logic             out_any_erc;
  logic [1:0]       out_first_erc;
  logic             mask_we;
  logic [OPW-1:0]   mask_adr;
  logic             mask_din;
  logic             cnt_clr;
  logic [CNTW-1:0]  erc_count;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] bx, ba, bb, bc, bs, bp;
  int            sat_exp [5];

  qupls_decode_erc_pipe #(
    .LANES(LANES), .INSTW(INSTW), .OPW(OPW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_lmask(in_lmask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_lmask(out_lmask),
    .out_erc(out_erc), .out_any_erc(out_any_erc),
    .out_first_erc(out_first_erc),
    .mask_we(mask_we), .mask_adr(mask_adr), .mask_din(mask_din),
    .cnt_clr(cnt_clr), .erc_count(erc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] mk(input logic [6:0] o0, input logic [6:0] o1,
                                       input logic [6:0] o2, input logic [6:0] o3,
                                       input logic [7:0] tag);
    logic [BW-1:0] b;
    b[0*INSTW +: INSTW] = {tag, 8'd0, 18'h2A5A5, o0};
    b[1*INSTW +: INSTW] = {tag, 8'd1, 18'h2A5A5, o1};
    b[2*INSTW +: INSTW] = {tag, 8'd2, 18'h2A5A5, o2};
    b[3*INSTW +: INSTW] = {tag, 8'd3, 18'h2A5A5, o3};
    return b;
  endfunction

  initial begin
    bx = mk(7'h05, 7'h12, 7'h05, 7'h40, 8'h11);
    ba = mk(7'h40, 7'h40, 7'h40, 7'h05, 8'hA0);
    bb = mk(7'h05, 7'h12, 7'h40, 7'h40, 8'hB0);
    bc = mk(7'h40, 7'h40, 7'h40, 7'h40, 8'hC0);
    bs = mk(7'h05, 7'h05, 7'h05, 7'h05, 8'h55);
    bp = mk(7'h40, 7'h40, 7'h12, 7'h40, 8'h77);
    sat_exp = '{0, 4, 8, 12, 15};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_lmask = '0;
    out_ready = 1'b1; mask_we = 1'b0; mask_adr = '0; mask_din = 1'b0; cnt_clr = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_in_ready", in_ready === 1'b0);
    chk("rst_out_valid", out_valid === 1'b0);
    chk("rst_out_instr", out_instr === '0);
    chk("rst_out_erc", out_erc === 4'b0000);
    chk("rst_any", out_any_erc === 1'b0);
    chk("rst_first", out_first_erc === 2'd0);
    chk("rst_count", erc_count === 4'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready === 1'b1);

    // Empty mask: nothing classified as ERC
    in_valid = 1'b1; in_instr = bx; in_lmask = 4'hF;
    tick();
    in_valid = 1'b0;
    chk("t1_valid", out_valid === 1'b1);
    chk("t1_instr", out_instr === bx);
    chk("t1_erc", out_erc === 4'b0000);
    chk("t1_any", out_any_erc === 1'b0);
    tick();
    chk("t1_drain", out_valid === 1'b0);
    chk("t1_count", erc_count === 4'd0);

    // Program opcode 0x05, then send the bundle next cycle
    mask_we = 1'b1; mask_adr = 7'h05; mask_din = 1'b1;
    tick();
    mask_we = 1'b0;
    in_valid = 1'b1; in_instr = bx; in_lmask = 4'hF;
    tick();
    in_valid = 1'b0;
    chk("t2_erc", out_erc === 4'b0101);
    chk("t2_first", out_first_erc === 2'd0);
    chk("t2_any", out_any_erc === 1'b1);
    chk("t2_count_pre", erc_count === 4'd0);
    tick();
    chk("t2_count", erc_count === 4'd2);

    // Lane mask 1011 with a same-cycle write of opcode 0x12
    in_valid = 1'b1; in_instr = bx; in_lmask = 4'b1011;
    mask_we = 1'b1; mask_adr = 7'h12; mask_din = 1'b1;
    tick();
    in_valid = 1'b0; mask_we = 1'b0;
    chk("t3_erc", out_erc === 4'b0001);
    chk("t3_lmask", out_lmask === 4'b1011);
    tick();
    chk("t3_count", erc_count === 4'd3);

    // New 0x12 mask bit visible on later bundles
    in_valid = 1'b1; in_instr = bx; in_lmask = 4'hF;
    tick();
    in_instr = bp;
    chk("t3b_erc", out_erc === 4'b0111);
    tick();
    in_valid = 1'b0;
    chk("t3c_count", erc_count === 4'd6);
    chk("t3c_erc", out_erc === 4'b0100);
    chk("t3c_first", out_first_erc === 2'd2);
    tick();
    chk("t3c_count2", erc_count === 4'd7);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_idle", erc_count === 4'd0);

    // Backpressure: A in output, B in skid, C stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = ba;
    tick();
    chk("bp_a_out", out_instr === ba);
    chk("bp_ready1", in_ready === 1'b1);
    in_instr = bb;
    tick();
    chk("bp_ready0", in_ready === 1'b0);
    chk("bp_a_hold", out_instr === ba);
    in_instr = bc;
    tick();
    chk("bp_a_hold2", out_instr === ba);
    chk("bp_a_erc", out_erc === 4'b1000);
    chk("bp_a_first", out_first_erc === 2'd3);
    out_ready = 1'b1;
    tick();
    chk("bp_b_out", out_instr === bb);
    chk("bp_b_erc", out_erc === 4'b0011);
    chk("bp_ready_back", in_ready === 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_c_out", out_instr === bc);
    chk("bp_c_any", out_any_erc === 1'b0);
    tick();
    chk("bp_drain", out_valid === 1'b0);
    chk("bp_count", erc_count === 4'd3);

    // Saturation: four ERC lanes per bundle, back to back
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    in_valid = 1'b1; in_instr = bs; in_lmask = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("sat_valid", out_valid === 1'b1);
      chk("sat_count", erc_count === 4'(sat_exp[k]));
    end
    in_valid = 1'b0;
    tick();
    chk("sat_hold", erc_count === 4'd15);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_vs_incr", erc_count === 4'd0);
    chk("clr_drain", out_valid === 1'b0);

    // Reset with output and skid both full
    in_valid = 1'b1; in_instr = bs;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_count", erc_count === 4'd4);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = ba;
    tick();
    in_instr = bb;
    tick();
    in_valid = 1'b0;
    chk("full_ready", in_ready === 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", out_valid === 1'b0);
    chk("mid_rst_count", erc_count === 4'd0);
    chk("mid_rst_ready", in_ready === 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("after_rst_ready", in_ready === 1'b1);
    in_valid = 1'b1; in_instr = bx; in_lmask = 4'hF;
    tick();
    in_valid = 1'b0;
    chk("mask_cleared_instr", out_instr === bx);
    chk("mask_cleared_erc", out_erc === 4'b0000);
    tick();
    chk("no_replay", out_valid === 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
